muldiv_unit: RTL and testbench

- Iterative multiply/divide coprocessor for the execute stage. Owns the architectural HI/LO registers.
- Supports signed and unsigned MULT/DIV plus MTHI/MTLO. Operand width is parametrised.
- Runs multi-cycle in the background. Raises a stall to the pipeline only when HI/LO is read while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/md_iter_step.sv | 33 +++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide coprocessor. The decode stage also imports
// this package to map its aluop codes onto md_op_t.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } md_state_t;

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply (mode_i=0) or restoring divide (mode_i=1).
// {acc,q} is the running product, or the partial remainder and dividend/quotient.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    assign sum     = q_i[0] ? ({1'b0, acc_i} + {1'b0, b_i}) : {1'b0, acc_i};
    assign shifted = {acc_i, q_i[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, b_i});

    always_comb begin
        if (mode_i) begin
            // The restored remainder is always below the divisor, so a WIDTH-bit subtract suffices.
            acc_o = ge ? (shifted[WIDTH-1:0] - b_i) : shifted[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], ge};
        end else begin
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO. Runs in the background and only
// stalls the pipeline when HI/LO is read while an operation is in flight.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] step_acc, step_q;
    logic             is_md_op, is_signed, is_div_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0] quo_res, rem_res, res_hi, res_lo;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (div_q),
        .acc_i  (acc_q),
        .q_i    (q_q),
        .b_i    (b_q),
        .acc_o  (step_acc),
        .q_o    (step_q)
    );

    assign is_md_op  = op_valid && (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    assign a_neg     = is_signed && rs_val[WIDTH-1];
    assign b_neg     = is_signed && rt_val[WIDTH-1];
    assign mag_a     = a_neg ? -rs_val : rs_val;
    assign mag_b     = b_neg ? -rt_val : rt_val;

    // Sign correction; overflow (most-negative / -1) needs no special case.
    assign prod_res = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
    assign quo_res  = neg_q ? -q_q : q_q;
    assign rem_res  = rneg_q ? -acc_q : acc_q;
    assign res_hi   = div_q ? rem_res : prod_res[2*WIDTH-1:WIDTH];
    assign res_lo   = div_q ? (dz_q ? '1 : quo_res) : prod_res[WIDTH-1:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = IDLE;
            end
            default: ;
        endcase

        // Requests override RUN progress (abort) but never the FIX write above.
        if (flush) begin
            state_d = IDLE;
        end else if (is_md_op) begin
            state_d = RUN;
            cnt_d   = CNT_W'(WIDTH);
            acc_d   = '0;
            q_d     = is_div_op ? mag_a : mag_b;
            b_d     = is_div_op ? mag_b : mag_a;
            div_d   = is_div_op;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = is_div_op && (rt_val == '0);
        end else if (op_valid && op == MD_MTHI) begin
            state_d = IDLE;
            hi_d    = rs_val;
        end else if (op_valid && op == MD_MTLO) begin
            state_d = IDLE;
            lo_d    = rs_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == FIX);
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = rd_req && busy_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a table of MULT/DIV vectors plus hand-written
// sequences for stall, flush, abort, restart and asynchronous reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, op_valid, flush, rd_req;
    logic [2:0]   op;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .rd_req   (rd_req),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request for exactly one rising edge; call from the low clock phase.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op       = o;
        rs_val   = a;
        rt_val   = b;
        op_valid = 1'b1;
        @(posedge clock);
        #1 op_valid = 1'b0;
    endtask

    task automatic run_wait(output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        @(negedge clock);
        while (busy === 1'b1 && cycles < 100) begin
            if (done === 1'b1) dones++;
            cycles++;
            @(negedge clock);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, dn, found;

        vecs[0]  = '{"multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m7x3", MD_MULT,  32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_m7d2",  MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{"divu_dz",   MD_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[5]  = '{"div_m5dz",  MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6]  = '{"mult_mnsq", MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{"divu_d16",  MD_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
        vecs[8]  = '{"div_7dm2",  MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"mult_neg1", MD_MULT,  32'd1234,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFB2E};
        vecs[10] = '{"multu_zero", MD_MULTU, 32'h12345678, 32'd0,       32'h00000000, 32'h00000000};

        reset = 1'b1; op_valid = 1'b0; flush = 1'b0; rd_req = 1'b0;
        op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rd_req = 1'b1;
        @(negedge clock);
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_stall", 64'(stall), 64'h0);
        rd_req = 1'b0;

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            run_wait(cyc, dn);
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
            check({vecs[i].name, "_busycyc"}, 64'(cyc), 64'd33);
            check({vecs[i].name, "_dones"}, 64'(dn), 64'd1);
        end

        // Stall held while busy, including the done cycle; released the cycle after.
        issue(MD_MULTU, 32'd5, 32'd6);
        rd_req = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            check($sformatf("stall_cyc%0d", k), 64'(stall), (k <= 33) ? 64'd1 : 64'd0);
            if (k == 33) check("stall_done_cyc", 64'(done), 64'd1);
        end
        rd_req = 1'b0;
        check("stall_hi", 64'(hi), 64'h0);
        check("stall_lo", 64'(lo), 64'd30);

        // MTHI/MTLO are single-cycle, no busy, no done.
        issue(MD_MTHI, 32'h11, 32'h0);
        @(negedge clock);
        check("mthi_hi", 64'(hi), 64'h11);
        check("mthi_busy", 64'(busy), 64'h0);
        issue(MD_MTLO, 32'h22, 32'h0);
        @(negedge clock);
        check("mtlo_lo", 64'(lo), 64'h22);
        check("mtlo_done", 64'(done), 64'h0);

        // Flush mid-RUN: no done, HI/LO untouched.
        issue(MD_MULT, 32'd2, 32'd3);
        dn = 0;
        repeat (9) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
        end
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("flush_busy", 64'(busy), 64'h0);
        repeat (40) begin
            if (done === 1'b1) dn++;
            @(negedge clock);
        end
        check("flush_dones", 64'(dn), 64'd0);
        check("flush_hi", 64'(hi), 64'h11);
        check("flush_lo", 64'(lo), 64'h22);

        // MTLO during a DIVU aborts it and performs the write.
        issue(MD_DIVU, 32'd9, 32'd2);
        repeat (4) @(negedge clock);
        issue(MD_MTLO, 32'hABCD, 32'h0);
        @(negedge clock);
        check("abort_lo", 64'(lo), 64'hABCD);
        check("abort_hi", 64'(hi), 64'h11);
        check("abort_busy", 64'(busy), 64'h0);
        dn = 0;
        repeat (40) begin
            if (done === 1'b1) dn++;
            @(negedge clock);
        end
        check("abort_dones", 64'(dn), 64'd0);
        check("abort_lo_hold", 64'(lo), 64'hABCD);

        // Unknown op code is ignored.
        issue(3'd6, 32'h5555, 32'h5555);
        @(negedge clock);
        check("unk_busy", 64'(busy), 64'h0);
        check("unk_hi", 64'(hi), 64'h11);
        check("unk_lo", 64'(lo), 64'hABCD);

        // New MULTU mid-RUN restarts with the new operands; only one done.
        issue(MD_MULTU, 32'd3, 32'd4);
        dn = 0;
        repeat (9) begin
            @(negedge clock);
            if (done === 1'b1) dn++;
        end
        issue(MD_MULTU, 32'd5, 32'd7);
        run_wait(cyc, found);
        check("restart_busycyc", 64'(cyc), 64'd33);
        check("restart_dones", 64'(dn + found), 64'd1);
        check("restart_hi", 64'(hi), 64'h0);
        check("restart_lo", 64'(lo), 64'd35);

        // Flush in the FIX cycle does not cancel the write.
        issue(MD_MULTU, 32'd6, 32'd7);
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            @(negedge clock);
            if (done === 1'b1) found = 1;
        end
        check("fixflush_seen_done", 64'(found), 64'd1);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        @(negedge clock);
        check("fixflush_lo", 64'(lo), 64'd42);
        check("fixflush_hi", 64'(hi), 64'h0);
        check("fixflush_busy", 64'(busy), 64'h0);

        // Asynchronous reset mid-RUN clears state before any clock edge.
        issue(MD_MULTU, 32'd9, 32'd9);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("areset_busy", 64'(busy), 64'h0);
        check("areset_hi", 64'(hi), 64'h0);
        check("areset_lo", 64'(lo), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("areset_done", 64'(done), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
